// File: rtl/fifo_burst_reader.sv
// Burst read master for the synchronous FIFO: waits for a burst's worth of data,
// reads it out through a 2-entry skid buffer and presents it on a valid/ready stream.
//   state | meaning
//   IDLE  | waiting for lvl >= BURST, or flush with data stored
//   READ  | issuing FIFO reads until rd_left reaches 0
//   TAIL  | all reads issued, draining until out_left reaches 0
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LVL_W = 3,
    parameter int BURST = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             fifo_rd_o,
    input  logic [WIDTH-1:0] fifo_q_i,
    input  logic             fifo_empty_i,
    input  logic             fifo_full_i,
    input  logic [LVL_W-1:0] fifo_usedw_i,
    input  logic             flush_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             m_last_o,
    output logic             busy_o
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE, READ, TAIL} state_t;

    state_t           state_q;
    logic [CW-1:0]    rd_left_q;
    logic [CW-1:0]    out_left_q;
    logic             pend_q;
    logic [1:0]       buf_cnt_q;
    logic [WIDTH-1:0] buf0_q;
    logic [WIDTH-1:0] buf1_q;

    logic [31:0]      lvl;
    logic             pop;
    logic [2:0]       occ;

    // usedw wraps to 0 when full, so the full flag stands in for a complete burst
    assign lvl = fifo_full_i ? 32'(BURST) : 32'(fifo_usedw_i);
    assign pop = (buf_cnt_q != 2'd0) && m_ready_i;
    assign occ = {1'b0, buf_cnt_q} + {2'b00, pend_q} - {2'b00, pop};

    assign fifo_rd_o = (state_q == READ) && (rd_left_q != '0) && !fifo_empty_i && (occ < 3'd2);
    assign m_valid_o = (buf_cnt_q != 2'd0);
    assign m_data_o  = buf0_q;
    assign m_last_o  = m_valid_o && (out_left_q == CW'(1));
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_left_q  <= '0;
            out_left_q <= '0;
            pend_q     <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            pend_q <= fifo_rd_o;

            case ({pop, pend_q})
                2'b10: begin
                    buf0_q    <= buf1_q;
                    buf_cnt_q <= buf_cnt_q - 2'd1;
                end
                2'b01: begin
                    if (buf_cnt_q == 2'd0) buf0_q <= fifo_q_i;
                    else                   buf1_q <= fifo_q_i;
                    buf_cnt_q <= buf_cnt_q + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd1) begin
                        buf0_q <= fifo_q_i;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= fifo_q_i;
                    end
                end
                default: ;
            endcase

            if (pop && (out_left_q != '0)) out_left_q <= out_left_q - CW'(1);

            case (state_q)
                IDLE: begin
                    if (lvl >= 32'(BURST)) begin
                        rd_left_q  <= CW'(BURST);
                        out_left_q <= CW'(BURST);
                        state_q    <= READ;
                    end else if (flush_i && !fifo_empty_i) begin
                        rd_left_q  <= CW'(lvl);
                        out_left_q <= CW'(lvl);
                        state_q    <= READ;
                    end
                end
                READ: begin
                    if (fifo_rd_o) rd_left_q <= rd_left_q - CW'(1);
                    if ((rd_left_q == '0) || (fifo_rd_o && (rd_left_q == CW'(1)))) state_q <= TAIL;
                end
                TAIL: begin
                    if ((out_left_q == '0) || (pop && (out_left_q == CW'(1)))) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO plus a stream-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_burst_reader;

    localparam int W     = 8;
    localparam int LW    = 3;
    localparam int B     = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_rd;
    logic [W-1:0]  fifo_q = '0;
    logic          fifo_empty;
    logic          fifo_full;
    logic [LW-1:0] fifo_usedw;
    logic          flush;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic          m_last;
    logic          busy;

    logic          wr_en;
    logic [W-1:0]  wr_data;

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(W), .LVL_W(LW), .BURST(B)) dut (
        .clk_i(clk), .rst_i(rst), .fifo_rd_o(fifo_rd), .fifo_q_i(fifo_q),
        .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full), .fifo_usedw_i(fifo_usedw),
        .flush_i(flush), .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
        .m_last_o(m_last), .busy_o(busy)
    );

    // environment FIFO: registered q and level, combinational flags, not reset by rst
    logic [W-1:0] mem [DEPTH];
    int wp = 0, rp = 0, cnt = 0;
    assign fifo_empty = (cnt == 0);
    assign fifo_full  = (cnt == DEPTH);
    assign fifo_usedw = LW'(cnt);

    always @(posedge clk) begin
        automatic bit rd_ok = fifo_rd && (cnt > 0);
        automatic bit wr_ok = wr_en && (cnt < DEPTH);
        if (rd_ok) begin
            fifo_q <= mem[rp];
            rp     <= (rp + 1) % DEPTH;
        end
        if (wr_ok) begin
            mem[wp] <= wr_data;
            wp      <= (wp + 1) % DEPTH;
        end
        cnt <= cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: words taken from the FIFO but not yet delivered, and burst bookkeeping
    logic [W-1:0] rdq[$];
    int           rdc[$];
    bit           mb_active = 0;
    int           m_rem = 0;
    int           m_rdleft = 0;
    bit           prev_hold = 0;
    logic [W-1:0] prev_data = '0;

    logic [W-1:0] pop_d[$];
    bit           pop_l[$];
    int           pop_c[$];
    int           rd_c[$];

    always @(negedge clk) begin
        bit exp_valid, exp_pop, exp_rd, was_idle;
        int lvl, len;
        if (rst) begin
            rdq.delete();
            rdc.delete();
            mb_active = 0;
            m_rem     = 0;
            m_rdleft  = 0;
            prev_hold = 0;
        end else begin
            exp_valid = (rdq.size() > 0) && (rdc[0] <= cyc - 2);
            exp_pop   = exp_valid && m_ready;
            exp_rd    = mb_active && (m_rdleft > 0) && !fifo_empty &&
                        ((rdq.size() - (exp_pop ? 1 : 0)) < 2);
            chk("m_valid", m_valid, exp_valid);
            chk("busy", busy, mb_active);
            chk("fifo_rd", fifo_rd, exp_rd);
            if (m_valid) chk("m_last", m_last, (m_rem == 1));
            else         chk("m_last_idle", m_last, 0);
            if (m_valid && rdq.size() > 0) chk("m_data", m_data, rdq[0]);
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;

            if (m_valid && m_ready) begin
                pop_d.push_back(m_data);
                pop_l.push_back(m_last);
                pop_c.push_back(cyc);
            end

            was_idle = !mb_active;
            if (fifo_rd && !fifo_empty) begin
                rdq.push_back(mem[rp]);
                rdc.push_back(cyc);
                rd_c.push_back(cyc);
                if (m_rdleft > 0) m_rdleft--;
            end
            if (exp_pop) begin
                void'(rdq.pop_front());
                void'(rdc.pop_front());
                if (m_rem > 0) m_rem--;
                if (m_rem == 0) mb_active = 0;
            end
            if (was_idle) begin
                lvl = fifo_full ? B : int'(fifo_usedw);
                len = 0;
                if (lvl >= B)                     len = B;
                else if (flush && !fifo_empty)    len = lvl;
                if (len > 0) begin
                    mb_active = 1;
                    m_rem     = len;
                    m_rdleft  = len;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic clear_logs();
        pop_d.delete();
        pop_l.delete();
        pop_c.delete();
        rd_c.delete();
    endtask

    task automatic check_stream(input string name, input logic [W-1:0] first, input int n,
                                input int last_a, input int last_b);
        chk({name, "_count"}, pop_d.size(), n);
        for (int i = 0; i < pop_d.size() && i < n; i++) begin
            chk({name, "_data"}, pop_d[i], first + W'(i));
            chk({name, "_last"}, pop_l[i], (i == last_a) || (i == last_b));
        end
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_fifo_rd"}, fifo_rd, 0);
        chk({name, "_m_valid"}, m_valid, 0);
        chk({name, "_m_data"}, m_data, 0);
        chk({name, "_m_last"}, m_last, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        bit seen;
        bit drained;
        logic [6:0] rdy_pat;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; m_ready = 1'b1;
        step();
        step();
        check_zero_outputs("reset");
        rst = 1'b0;
        step();

        // full burst at 1 word/clock
        clear_logs();
        for (int i = 0; i < 4; i++) write_word(8'h11 + W'(i));
        repeat (15) step();
        check_stream("t1", 8'h11, 4, 3, -1);
        chk("t1_rd_count", rd_c.size(), 4);
        for (int i = 0; i < rd_c.size() && i < 4; i++) chk("t1_rd_consec", rd_c[i], rd_c[0] + i);
        for (int i = 0; i < pop_c.size() && i < 4 && rd_c.size() > 0; i++)
            chk("t1_pop_cycle", pop_c[i], rd_c[0] + 2 + i);
        chk("t1_busy_done", busy, 0);

        // short burst only on flush
        clear_logs();
        for (int i = 0; i < 3; i++) write_word(8'h21 + W'(i));
        repeat (20) step();
        chk("t2_no_read", rd_c.size(), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (12) step();
        check_stream("t2", 8'h21, 3, 2, -1);

        // fill to full behind reset: usedw wraps to 0 yet a full burst starts
        clear_logs();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) write_word(8'hA0 + W'(i));
        chk("t3_full", fifo_full, 1);
        chk("t3_usedw_wrap", fifo_usedw, 0);
        rst = 1'b0;
        repeat (25) step();
        check_stream("t3", 8'hA0, 8, 3, 7);

        // back-pressure pattern
        clear_logs();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(8'h31 + W'(i));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (m_valid) seen = 1;
            else step();
        end
        chk("t4_valid_seen", seen, 1);
        rdy_pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            m_ready = rdy_pat[i];
            step();
        end
        m_ready = 1'b1;
        repeat (10) step();
        check_stream("t4", 8'h31, 4, 3, -1);

        // reset with two words buffered; those are lost, the rest comes out in order
        clear_logs();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'h41 + W'(i));
        repeat (8) step();
        chk("t5_credit_stall", rd_c.size(), 2);
        chk("t5_buffered", m_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero_outputs("t5_after_rst");
        m_ready = 1'b1;
        clear_logs();
        repeat (10) step();
        chk("t5_no_restart", rd_c.size(), 0);
        write_word(8'h45);
        write_word(8'h46);
        repeat (15) step();
        check_stream("t5", 8'h43, 4, 3, -1);

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 2) == 0) && (cnt < DEPTH);
            wr_data = W'($urandom);
            flush   = ($urandom_range(0, 9) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; wr_en = 1'b0; flush = 1'b1; m_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 200 && !drained; i++) begin
            step();
            if (cnt == 0 && !busy && !m_valid) drained = 1;
        end
        chk("drain_done", drained, 1);
        flush = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous FIFO (registered read data, combinational empty/full, registered fill level).
- Waits until a burst's worth of data is stored, then issues read requests to the FIFO.
- Absorbs the FIFO's 1-cycle read latency in a 2-entry skid buffer and presents words on a valid/ready stream.
- Marks the last word of each burst; sits between the FIFO and downstream packet/serial logic.

Parameters:
- WIDTH, 8, data word width; must match the FIFO.
- LVL_W, 3, width of the FIFO fill-level input.
- BURST, 4, words per normal burst; 1 <= BURST <= FIFO depth.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- fifo_rd  output  1  read request to the FIFO.
- fifo_q  input  WIDTH  FIFO read data; valid the cycle after an accepted fifo_rd.
- fifo_empty  input  1  FIFO empty flag.
- fifo_full  input  1  FIFO full flag.
- fifo_usedw  input  LVL_W  FIFO fill level; meaningless when fifo_full=1.
- flush  input  1  level-sensitive; permits a short burst of whatever is stored.
- m_valid  output  1  output word valid.
- m_data  output  WIDTH  output word.
- m_ready  input  1  downstream accepts the word when m_valid & m_ready.
- m_last  output  1  qualifies m_data as the final word of the burst.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - Outputs go to fifo_rd=0, m_valid=0, m_data=0, m_last=0, busy=0.
  - State goes to IDLE; counters and skid buffer are cleared.
  - A reset mid-burst discards in-flight and buffered words. Those words are lost from the FIFO (documented, not recovered).
- Effective level: lvl = BURST if fifo_full=1; otherwise lvl = fifo_usedw.
- IDLE:
  - If lvl >= BURST, load len = BURST.
  - Else if flush=1 and fifo_empty=0, load len = lvl.
  - On either load: set rd_left = len and out_left = len, then go to READ.
  - Evaluated once per cycle; the load takes effect at the next edge.
- READ:
  - fifo_rd = (rd_left != 0) & ~fifo_empty & ((buf_cnt + pend - pop) < 2).
  - pend = 1 if fifo_rd was asserted in the previous cycle.
  - pop = m_valid & m_ready.
  - Each asserted fifo_rd decrements rd_left.
  - When rd_left reaches 0, go to TAIL.
- TAIL: fifo_rd=0. When out_left reaches 0, go to IDLE. A new burst may start at the earliest one cycle after entering IDLE.
- Data path:
  - fifo_q is captured into the skid buffer on the cycle after an issued fifo_rd.
  - m_data/m_valid come from the buffer head. Order is FIFO order; no reordering or duplication.
  - With m_ready held at 1, sustained throughput is 1 word/clock.
  - Latency from the first fifo_rd to the first m_valid is 2 cycles.
- Handshake:
  - Once m_valid=1, m_valid and m_data stay stable until accepted.
  - m_ready=0 never causes loss; reads throttle via the credit rule.
  - m_valid does not depend combinationally on m_ready.
- m_last = m_valid & (out_left == 1). out_left decrements on each pop.
- Width rules:
  - rd_left and out_left are clog2(BURST+1) bits and never underflow.
  - lvl is compared unsigned.
- Boundary conditions:
  - fifo_empty=1 in READ (external misuse) stalls reads; no wrong data is emitted.
  - flush deasserting mid-burst has no effect; len is latched.
  - fifo_full with usedw wrapped to 0 still starts a full burst.
  - Simultaneous capture and pop in one cycle keeps buf_cnt constant.

Test Plan:
- Write 4 words (0x11..0x14), m_ready=1 -> fifo_rd high 4 consecutive cycles; m_data 0x11..0x14 on 4 consecutive cycles starting 2 cycles after the first rd; m_last only with 0x14; busy returns to 0 afterwards.
- Write 3 words with flush=0 -> no fifo_rd for 20 cycles. Then pulse flush for 1 cycle -> 3 words emitted, m_last on the 3rd.
- 8-deep FIFO filled to full (usedw wraps to 0) -> a burst of 4 (0xA0..0xA3) starts. A second burst follows and empties the FIFO; the total order 0xA0..0xA7 is preserved.
- Burst of 4 with m_ready toggling 1,0,0,1,0,1,1 -> no word lost or duplicated; m_data stable while m_valid=1 & m_ready=0; fifo_rd never makes buf_cnt+pend exceed 2.
- Assert rst for 1 cycle while 2 words are still buffered -> next cycle all outputs are 0 and state is IDLE. The next burst starts only when lvl >= 4 again and emits the remaining FIFO data in order.
